// File: rtl/pwm_pkg.sv
// Shared constants for the multi-channel PWM generator.
package pwm_pkg;
  localparam logic ALIGN_EDGE = 1'b0;
  localparam logic ALIGN_CENTER = 1'b1;
  localparam int CH_DEF = 4;
  localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/pwm_ch_cmp.sv
// One PWM compare channel: active duty register, compare and output flop.
module pwm_ch_cmp
  import pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] shadow_duty,
  output logic             pwm
);

  logic [CNT_W-1:0] duty;

  // Compare uses the duty of the current period; a load lands for the next.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty <= '0;
      pwm  <= 1'b0;
    end else begin
      pwm <= en && (cnt < duty);
      if (load) duty <= shadow_duty;
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared period counter, double-buffered config,
// edge or center alignment.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int CH    = CH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                en,
  input  logic                cfg_wr,
  input  logic [CNT_W-1:0]    cfg_top,
  input  logic                cfg_align,
  input  logic [CH*CNT_W-1:0] cfg_duty,
  output logic                cfg_pending,
  output logic                period_tick,
  output logic [CH-1:0]       pwm_out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_DOWN = 2'd2;

  logic [1:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    act_top;
  logic                act_align;
  logic [CNT_W-1:0]    sh_top;
  logic                sh_align;
  logic [CH*CNT_W-1:0] sh_duty;

  logic [CNT_W-1:0]    nx_top;
  logic                nx_align;
  logic [CH*CNT_W-1:0] nx_duty;
  logic                terminal;
  logic                load;

  // A write in the loading cycle passes straight through to the active set.
  assign nx_top   = cfg_wr ? cfg_top   : sh_top;
  assign nx_align = cfg_wr ? cfg_align : sh_align;
  assign nx_duty  = cfg_wr ? cfg_duty  : sh_duty;

  always_comb begin
    terminal = 1'b0;
    if (act_align == ALIGN_EDGE) begin
      terminal = (cnt == act_top);
    end else begin
      terminal = (state == ST_DOWN && cnt == CNT_W'(1))
              || (act_top <= CNT_W'(1) && cnt == act_top);
    end
  end

  assign load = !en || terminal;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      act_top     <= '0;
      act_align   <= ALIGN_EDGE;
      sh_top      <= '0;
      sh_align    <= ALIGN_EDGE;
      sh_duty     <= '0;
      cfg_pending <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      if (cfg_wr) begin
        sh_top   <= cfg_top;
        sh_align <= cfg_align;
        sh_duty  <= cfg_duty;
      end
      if (!en) begin
        state       <= ST_IDLE;
        cnt         <= '0;
        act_top     <= nx_top;
        act_align   <= nx_align;
        cfg_pending <= 1'b0;
        period_tick <= 1'b0;
      end else begin
        period_tick <= (cnt == '0);
        if (terminal) begin
          state       <= ST_UP;
          cnt         <= '0;
          act_top     <= nx_top;
          act_align   <= nx_align;
          cfg_pending <= 1'b0;
        end else begin
          if (cfg_wr) cfg_pending <= 1'b1;
          if (act_align == ALIGN_EDGE) begin
            state <= ST_UP;
            cnt   <= cnt + CNT_W'(1);
          end else if (state == ST_DOWN) begin
            cnt <= cnt - CNT_W'(1);
          end else if (cnt == act_top) begin
            state <= ST_DOWN;
            cnt   <= cnt - CNT_W'(1);
          end else begin
            state <= ST_UP;
            cnt   <= cnt + CNT_W'(1);
          end
        end
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    pwm_ch_cmp #(
      .CNT_W(CNT_W)
    ) u_cmp (
      .clk        (sys_clk),
      .rst        (sys_rst),
      .en         (en),
      .load       (load),
      .cnt        (cnt),
      .shadow_duty(nx_duty[g*CNT_W +: CNT_W]),
      .pwm        (pwm_out[g])
    );
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed self-checking bench for pwm_multi (CH=4, CNT_W=8).
module tb_pwm_multi;

  logic        clk;
  logic        rst;
  logic        en;
  logic        cfg_wr;
  logic [7:0]  cfg_top;
  logic        cfg_align;
  logic [31:0] cfg_duty;
  logic        cfg_pending;
  logic        period_tick;
  logic [3:0]  pwm_out;

  int total;
  int bad;

  pwm_multi #(
    .CH   (4),
    .CNT_W(8)
  ) dut (
    .sys_clk    (clk),
    .sys_rst    (rst),
    .en         (en),
    .cfg_wr     (cfg_wr),
    .cfg_top    (cfg_top),
    .cfg_align  (cfg_align),
    .cfg_duty   (cfg_duty),
    .cfg_pending(cfg_pending),
    .period_tick(period_tick),
    .pwm_out    (pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [7:0] top, input logic al,
                         input logic [7:0] d3, input logic [7:0] d2,
                         input logic [7:0] d1, input logic [7:0] d0);
    cfg_top   = top;
    cfg_align = al;
    cfg_duty  = {d3, d2, d1, d0};
  endtask

  task automatic load_idle();
    en     = 1'b0;
    cfg_wr = 1'b1;
    step();
    cfg_wr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b1;
    cfg_wr = 1'b1;
    set_cfg(8'd5, 1'b0, 8'd3, 8'd3, 8'd3, 8'd3);
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({cfg_pending, period_tick, pwm_out} !== 6'b0) begin
        $display("FAIL reset cyc=%0d got=%b want=000000", i,
                 {cfg_pending, period_tick, pwm_out});
        bad++;
      end
    end
    rst = 1'b0;
    cfg_wr = 1'b0;
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      total++;
      if ({cfg_pending, pwm_out} !== 5'b0) begin
        $display("FAIL idle cyc=%0d got=%b want=00000", i,
                 {cfg_pending, pwm_out});
        bad++;
      end
    end
  endtask

  task automatic test_edge();
    logic [4:0] exp;
    int ph;
    set_cfg(8'd9, 1'b0, 8'd10, 8'd9, 8'd3, 8'd0);
    load_idle();
    en = 1'b1;
    for (int k = 0; k < 30; k++) begin
      step();
      ph = k % 10;
      exp = {ph == 0, 1'b1, ph < 9, ph < 3, 1'b0};
      total++;
      if ({period_tick, pwm_out} !== exp) begin
        $display("FAIL edge k=%0d got=%b want=%b", k,
                 {period_tick, pwm_out}, exp);
        bad++;
      end
    end
  endtask

  task automatic test_center();
    logic [3:0] tbl [8];
    logic [4:0] exp;
    tbl = '{4'b1110, 4'b1110, 4'b1100, 4'b1100,
            4'b1000, 4'b1100, 4'b1100, 4'b1110};
    set_cfg(8'd4, 1'b1, 8'd5, 8'd4, 8'd2, 8'd0);
    load_idle();
    en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      exp = {(k % 8) == 0, tbl[k % 8]};
      total++;
      if ({period_tick, pwm_out} !== exp) begin
        $display("FAIL center k=%0d got=%b want=%b", k,
                 {period_tick, pwm_out}, exp);
        bad++;
      end
    end
  endtask

  task automatic test_mid_update();
    logic [4:0] exp;
    logic       ph_hi;
    set_cfg(8'd9, 1'b0, 8'd3, 8'd3, 8'd3, 8'd3);
    load_idle();
    en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k == 4) begin
        set_cfg(8'd9, 1'b0, 8'd6, 8'd6, 8'd6, 8'd6);
        cfg_wr = 1'b1;
      end
      step();
      cfg_wr = 1'b0;
      ph_hi = (k < 10) ? (k < 3) : ((k - 10) < 6);
      exp = {(k >= 4 && k <= 8), {4{ph_hi}}};
      total++;
      if ({cfg_pending, pwm_out} !== exp) begin
        $display("FAIL mid_update k=%0d got=%b want=%b", k,
                 {cfg_pending, pwm_out}, exp);
        bad++;
      end
    end
  endtask

  task automatic test_terminal_write();
    logic [5:0] exp;
    logic       hi;
    logic       tk;
    set_cfg(8'd9, 1'b0, 8'd3, 8'd3, 8'd3, 8'd3);
    load_idle();
    en = 1'b1;
    for (int k = 0; k < 25; k++) begin
      if (k == 9) begin
        set_cfg(8'd4, 1'b0, 8'd2, 8'd2, 8'd2, 8'd2);
        cfg_wr = 1'b1;
      end
      step();
      cfg_wr = 1'b0;
      if (k < 10) begin
        hi = (k < 3);
        tk = (k == 0);
      end else begin
        hi = ((k - 10) % 5) < 2;
        tk = ((k - 10) % 5) == 0;
      end
      exp = {1'b0, tk, {4{hi}}};
      total++;
      if ({cfg_pending, period_tick, pwm_out} !== exp) begin
        $display("FAIL term_write k=%0d got=%b want=%b", k,
                 {cfg_pending, period_tick, pwm_out}, exp);
        bad++;
      end
    end
  endtask

  task automatic test_en_drop_and_reset();
    logic [4:0] exp;
    set_cfg(8'd9, 1'b0, 8'd5, 8'd5, 8'd5, 8'd5);
    load_idle();
    en = 1'b1;
    step();
    step();
    total++;
    if (pwm_out !== 4'hF) begin
      $display("FAIL en_drop_pre got=%b want=1111", pwm_out);
      bad++;
    end
    en = 1'b0;
    step();
    total++;
    if ({period_tick, pwm_out} !== 5'b0) begin
      $display("FAIL en_drop got=%b want=00000", {period_tick, pwm_out});
      bad++;
    end
    step();
    step();
    en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      exp = {k == 0, (k < 5) ? 4'hF : 4'h0};
      total++;
      if ({period_tick, pwm_out} !== exp) begin
        $display("FAIL re_enable k=%0d got=%b want=%b", k,
                 {period_tick, pwm_out}, exp);
        bad++;
      end
    end
    set_cfg(8'd7, 1'b0, 8'd1, 8'd1, 8'd1, 8'd1);
    cfg_wr = 1'b1;
    step();
    cfg_wr = 1'b0;
    total++;
    if (cfg_pending !== 1'b1) begin
      $display("FAIL pend_before_rst got=%b want=1", cfg_pending);
      bad++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({cfg_pending, period_tick, pwm_out} !== 6'b0) begin
      $display("FAIL mid_reset got=%b want=000000",
               {cfg_pending, period_tick, pwm_out});
      bad++;
    end
    for (int k = 0; k < 5; k++) begin
      step();
      total++;
      if ({cfg_pending, period_tick, pwm_out} !== 6'b010000) begin
        $display("FAIL post_reset k=%0d got=%b want=010000", k,
                 {cfg_pending, period_tick, pwm_out});
        bad++;
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    en = 1'b0;
    cfg_wr = 1'b0;
    cfg_top = '0;
    cfg_align = 1'b0;
    cfg_duty = '0;
    test_reset();
    test_edge();
    test_center();
    test_mid_update();
    test_terminal_write();
    test_en_drop_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
